pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage CPU core, the drop-in replacement for the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one control bundle, one data bundle and a destination-register index per entry. It adds a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and bubble gating of control bits. Downstream stages never see write enables on an empty or flushed slot.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/d_ffec_n.sv | 24 ++
 rtl/pipe_stage_reg.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
//   ST_*           : skid-mode state encoding (EMPTY / ONE / FULL)
//   EXMEM_*, RD_W  : default bundle widths at a stage boundary
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 102;
    localparam int RD_W         = 5;

    typedef logic [1:0] pipe_state_t;

endpackage

// File: rtl/d_ffec_n.sv
// WIDTH-bit D flip-flop with load enable and asynchronous active-low clear.
//   clk_i  : rising-edge clock
//   clrn_i : async clear, active low (q_o -> 0)
//   en_i   : load d_i on the clock edge when high
//   d_i    : next value
//   q_o    : stored value
module d_ffec_n #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i)
            q_o <= '0;
        else if (en_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake.
// Carries {ctrl, data, rd} per entry, strict FIFO order.
//   Clk, Clrn          : clock, async active-low reset
//   Flush              : synchronous squash of every held entry
//   In_valid/In_ready  : upstream handshake; In_ctrl/In_data/In_rd payload
//   Out_valid/Out_ready: downstream handshake; Out_ctrl/Out_data/Out_rd head
//   Count              : number of entries held (0..2)
// SKID=1: two entries (main = head, skid = overflow), In_ready registered.
// SKID=0: one entry, In_ready = !Out_valid | Out_ready.
// Out_ctrl is gated by Out_valid so an empty slot never asserts write enables.
module pipe_stage_reg #(
    parameter int CTRL_W = pipe_pkg::EXMEM_CTRL_W,
    parameter int DATA_W = pipe_pkg::EXMEM_DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              Flush,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [CTRL_W-1:0] In_ctrl,
    input  logic [DATA_W-1:0] In_data,
    input  logic [RD_W-1:0]   In_rd,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [CTRL_W-1:0] Out_ctrl,
    output logic [DATA_W-1:0] Out_data,
    output logic [RD_W-1:0]   Out_rd,
    output logic [1:0]        Count
);

    import pipe_pkg::ST_EMPTY;
    import pipe_pkg::ST_ONE;
    import pipe_pkg::ST_FULL;
    import pipe_pkg::pipe_state_t;

    localparam int E_W = CTRL_W + DATA_W + RD_W;

    logic [E_W-1:0] in_ent;
    logic [E_W-1:0] main_q;
    logic [E_W-1:0] main_d;
    logic           main_en;
    logic           out_valid_w;
    logic           in_ready_w;
    logic [1:0]     count_w;
    logic           in_fire;
    logic           out_fire;

    assign in_ent   = {In_ctrl, In_data, In_rd};
    assign in_fire  = In_valid & in_ready_w;
    assign out_fire = out_valid_w & Out_ready;

    // Head register, shared by both modes.
    d_ffec_n #(.WIDTH(E_W)) u_main (
        .clk_i (Clk),
        .clrn_i(Clrn),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    assign In_ready  = in_ready_w;
    assign Out_valid = out_valid_w;
    assign Count     = count_w;
    assign Out_ctrl  = main_q[E_W-1 -: CTRL_W] & {CTRL_W{out_valid_w}};
    assign Out_data  = main_q[RD_W +: DATA_W];
    assign Out_rd    = main_q[RD_W-1:0];

    generate
        if (SKID == 1) begin : g_skid
            pipe_state_t    state_q;
            pipe_state_t    state_d;
            logic [E_W-1:0] skid_q;
            logic [E_W-1:0] skid_d;
            logic           skid_en;

            d_ffec_n #(.WIDTH(E_W)) u_skid (
                .clk_i (Clk),
                .clrn_i(Clrn),
                .en_i  (skid_en),
                .d_i   (skid_d),
                .q_o   (skid_q)
            );

            always_ff @(posedge Clk or negedge Clrn) begin
                if (!Clrn)
                    state_q <= ST_EMPTY;
                else
                    state_q <= state_d;
            end

            always_comb begin
                state_d = state_q;
                main_en = 1'b0;
                main_d  = in_ent;
                skid_en = 1'b0;
                skid_d  = in_ent;
                if (Flush) begin
                    // Squash wins over any concurrent transfer; storage is
                    // zeroed so no stale control survives.
                    state_d = ST_EMPTY;
                    main_en = 1'b1;
                    main_d  = '0;
                    skid_en = 1'b1;
                    skid_d  = '0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                main_en = 1'b1;
                                state_d = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_en = 1'b1;
                            end else if (in_fire) begin
                                skid_en = 1'b1;
                                state_d = ST_FULL;
                            end else if (out_fire) begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // In_ready is low here, so only the drain matters.
                            if (out_fire) begin
                                main_en = 1'b1;
                                main_d  = skid_q;
                                state_d = ST_ONE;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            assign out_valid_w = (state_q != ST_EMPTY);
            assign in_ready_w  = (state_q != ST_FULL);
            assign count_w     = (state_q == ST_FULL) ? 2'd2 :
                                 (state_q == ST_ONE)  ? 2'd1 : 2'd0;
        end else begin : g_single
            logic valid_q;
            logic valid_d;

            d_ffec_n #(.WIDTH(1)) u_valid (
                .clk_i (Clk),
                .clrn_i(Clrn),
                .en_i  (1'b1),
                .d_i   (valid_d),
                .q_o   (valid_q)
            );

            always_comb begin
                main_en = in_fire | Flush;
                main_d  = Flush ? '0 : in_ent;
                if (Flush)
                    valid_d = 1'b0;
                else if (in_fire)
                    valid_d = 1'b1;
                else if (out_fire)
                    valid_d = 1'b0;
                else
                    valid_d = valid_q;
            end

            assign out_valid_w = valid_q;
            assign in_ready_w  = !valid_q | Out_ready;
            assign count_w     = {1'b0, valid_q};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (u1) and one
// SKID=0 instance (u0) share clock, reset and flush; handshakes are separate.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_stage_reg;

    localparam int CW = 4;
    localparam int DW = 102;
    localparam int RW = 5;

    logic Clk = 1'b0;
    logic Clrn;
    logic Flush;

    logic          v1, r1, iv1, ov1;
    logic [CW-1:0] ic1, oc1;
    logic [DW-1:0] id1, od1;
    logic [RW-1:0] ir1, or1;
    logic [1:0]    cnt1;

    logic          v0, r0, iv0, ov0;
    logic [CW-1:0] ic0, oc0;
    logic [DW-1:0] id0, od0;
    logic [RW-1:0] ir0, or0;
    logic [1:0]    cnt0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(1)) u1 (
        .Clk(Clk), .Clrn(Clrn), .Flush(Flush),
        .In_valid(v1), .In_ready(iv1), .In_ctrl(ic1), .In_data(id1), .In_rd(ir1),
        .Out_valid(ov1), .Out_ready(r1), .Out_ctrl(oc1), .Out_data(od1),
        .Out_rd(or1), .Count(cnt1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(0)) u0 (
        .Clk(Clk), .Clrn(Clrn), .Flush(Flush),
        .In_valid(v0), .In_ready(iv0), .In_ctrl(ic0), .In_data(id0), .In_rd(ir0),
        .Out_valid(ov0), .Out_ready(r0), .Out_ctrl(oc0), .Out_data(od0),
        .Out_rd(or0), .Count(cnt0)
    );

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic drive1(input logic v, input logic [CW-1:0] c, input int d, input logic [RW-1:0] rd);
        v1 = v; ic1 = c; id1 = DW'(d); ir1 = rd;
    endtask

    task automatic drive0(input logic v, input logic [CW-1:0] c, input int d, input logic [RW-1:0] rd);
        v0 = v; ic0 = c; id0 = DW'(d); ir0 = rd;
    endtask

    task automatic test_reset();
        Clrn = 1'b0; Flush = 1'b0;
        drive1(1'b0, '0, 0, '0); r1 = 1'b0;
        drive0(1'b0, '0, 0, '0); r0 = 1'b0;
        tick();
        checks++;
        if ({ov1, oc1, od1, or1, cnt1, iv1} !== {1'b0, 4'b0, 102'b0, 5'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_skid1: got v=%b c=%h d=%h rd=%h n=%0d ir=%b, want all 0 and ir=1",
                     ov1, oc1, od1, or1, cnt1, iv1);
        end
        checks++;
        if ({ov0, oc0, od0, or0, cnt0, iv0} !== {1'b0, 4'b0, 102'b0, 5'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_skid0: got v=%b c=%h d=%h rd=%h n=%0d ir=%b, want all 0 and ir=1",
                     ov0, oc0, od0, or0, cnt0, iv0);
        end
        Clrn = 1'b1;
    endtask

    task automatic test_fill();
        drive1(1'b1, 4'b1011, 1, 5'd7); r1 = 1'b0;
        tick();
        drive1(1'b0, '0, 0, '0);
        checks++;
        if ({ov1, oc1, od1, or1, cnt1, iv1} !== {1'b1, 4'b1011, 102'd1, 5'd7, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL fill: got v=%b c=%b d=%h rd=%0d n=%0d ir=%b, want v=1 c=1011 d=1 rd=7 n=1 ir=1",
                     ov1, oc1, od1, or1, cnt1, iv1);
        end
        r1 = 1'b1;
        tick();
        checks++;
        if ({ov1, oc1, cnt1} !== {1'b0, 4'b0, 2'd0}) begin
            errors++;
            $display("FAIL drain_gate: got v=%b c=%b n=%0d, want v=0 c=0000 n=0", ov1, oc1, cnt1);
        end
    endtask

    task automatic test_stream();
        r1 = 1'b1; r0 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            drive1(k < 8, 4'hF, k, RW'(k));
            drive0(k < 8, 4'hF, k, RW'(k));
            tick();
            checks++;
            if (k < 8) begin
                if ({ov1, od1, ov0, od0, iv1, iv0} !== {1'b1, DW'(k), 1'b1, DW'(k), 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL stream[%0d]: got s1 v=%b d=%0d s0 v=%b d=%0d ir=%b%b, want v=1 d=%0d ir=11",
                             k, ov1, od1, ov0, od0, iv1, iv0, k);
                end
            end else begin
                if ({ov1, ov0} !== 2'b00) begin
                    errors++;
                    $display("FAIL stream_end: got v1=%b v0=%b, want 0 0", ov1, ov0);
                end
            end
        end
        drive0(1'b0, '0, 0, '0); r0 = 1'b0;
    endtask

    task automatic test_skid();
        r1 = 1'b0;
        drive1(1'b1, 4'h1, 'hA, 5'd1);
        tick();
        checks++;
        if ({od1, cnt1, iv1} !== {102'hA, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL skid_a: got d=%h n=%0d ir=%b, want d=a n=1 ir=1", od1, cnt1, iv1);
        end
        drive1(1'b1, 4'h2, 'hB, 5'd2);
        tick();
        checks++;
        if ({ov1, od1, cnt1, iv1} !== {1'b1, 102'hA, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL skid_full: got v=%b d=%h n=%0d ir=%b, want v=1 d=a n=2 ir=0", ov1, od1, cnt1, iv1);
        end
        drive1(1'b1, 4'h3, 'hC, 5'd3);
        tick();
        checks++;
        if ({od1, cnt1, iv1} !== {102'hA, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL skid_hold: got d=%h n=%0d ir=%b, want d=a n=2 ir=0", od1, cnt1, iv1);
        end
        r1 = 1'b1;
        tick();
        checks++;
        if ({ov1, od1, or1, cnt1, iv1} !== {1'b1, 102'hB, 5'd2, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL skid_b: got v=%b d=%h rd=%0d n=%0d ir=%b, want v=1 d=b rd=2 n=1 ir=1",
                     ov1, od1, or1, cnt1, iv1);
        end
        tick();
        checks++;
        if ({ov1, oc1, od1, cnt1} !== {1'b1, 4'h3, 102'hC, 2'd1}) begin
            errors++;
            $display("FAIL skid_c: got v=%b c=%h d=%h n=%0d, want v=1 c=3 d=c n=1", ov1, oc1, od1, cnt1);
        end
        drive1(1'b0, '0, 0, '0);
        tick();
        checks++;
        if ({ov1, cnt1} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL skid_empty: got v=%b n=%0d, want v=0 n=0", ov1, cnt1);
        end
    endtask

    task automatic test_flush();
        r1 = 1'b0;
        drive1(1'b1, 4'hF, 'h11, 5'd1);
        tick();
        drive1(1'b1, 4'hF, 'h22, 5'd2);
        tick();
        Flush = 1'b1;
        drive1(1'b1, 4'hF, 'h33, 5'd3);
        tick();
        Flush = 1'b0;
        drive1(1'b0, '0, 0, '0);
        checks++;
        if ({ov1, oc1, cnt1, iv1} !== {1'b0, 4'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush_full: got v=%b c=%b n=%0d ir=%b, want v=0 c=0 n=0 ir=1", ov1, oc1, cnt1, iv1);
        end
        tick();
        checks++;
        if ({ov1, cnt1} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_lost: got v=%b n=%0d, want v=0 n=0", ov1, cnt1);
        end
        // Flush together with a consuming head leaves nothing behind.
        drive1(1'b1, 4'h5, 'h44, 5'd4);
        tick();
        drive1(1'b0, '0, 0, '0);
        r1 = 1'b1; Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++;
        if ({ov1, oc1, cnt1} !== {1'b0, 4'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_outfire: got v=%b c=%b n=%0d, want v=0 c=0 n=0", ov1, oc1, cnt1);
        end
    endtask

    task automatic test_async_reset();
        r1 = 1'b0;
        drive1(1'b1, 4'hE, 'h55, 5'd5);
        tick();
        drive1(1'b1, 4'hD, 'h66, 5'd6);
        tick();
        drive1(1'b0, '0, 0, '0);
        checks++;
        if (cnt1 !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre: got n=%0d, want n=2", cnt1);
        end
        Clrn = 1'b0;
        #1;
        checks++;
        if ({ov1, oc1, od1, or1, cnt1, iv1} !== {1'b0, 4'b0, 102'b0, 5'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL areset_now: got v=%b c=%h d=%h rd=%h n=%0d ir=%b, want all 0 and ir=1",
                     ov1, oc1, od1, or1, cnt1, iv1);
        end
        tick();
        Clrn = 1'b1;
        r1 = 1'b1;
        tick();
        checks++;
        if ({ov1, cnt1} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL areset_after: got v=%b n=%0d, want v=0 n=0", ov1, cnt1);
        end
    endtask

    task automatic test_single_stall();
        r0 = 1'b0;
        drive0(1'b1, 4'h9, 5, 5'd5);
        tick();
        drive0(1'b1, 4'h6, 6, 5'd6);
        #1;
        checks++;
        if ({ov0, od0, cnt0, iv0} !== {1'b1, 102'd5, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL s0_stall: got v=%b d=%0d n=%0d ir=%b, want v=1 d=5 n=1 ir=0", ov0, od0, cnt0, iv0);
        end
        tick();
        checks++;
        if ({ov0, oc0, od0} !== {1'b1, 4'h9, 102'd5}) begin
            errors++;
            $display("FAIL s0_hold: got v=%b c=%h d=%0d, want v=1 c=9 d=5", ov0, oc0, od0);
        end
        r0 = 1'b1;
        #1;
        checks++;
        if (iv0 !== 1'b1) begin
            errors++;
            $display("FAIL s0_ready_comb: got ir=%b, want 1", iv0);
        end
        tick();
        drive0(1'b0, '0, 0, '0);
        checks++;
        if ({ov0, oc0, od0, or0} !== {1'b1, 4'h6, 102'd6, 5'd6}) begin
            errors++;
            $display("FAIL s0_replace: got v=%b c=%h d=%0d rd=%0d, want v=1 c=6 d=6 rd=6", ov0, oc0, od0, or0);
        end
        tick();
        checks++;
        if ({ov0, oc0, cnt0} !== {1'b0, 4'b0, 2'd0}) begin
            errors++;
            $display("FAIL s0_empty: got v=%b c=%h n=%0d, want v=0 c=0 n=0", ov0, oc0, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_skid();
        test_flush();
        test_async_reset();
        test_single_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
